// File: rtl/key_expander_if.sv
// Bundle of key-load, status and round-key read signals between the AES key
// schedule and its user.
interface key_expander_if;
    logic         key_load;
    logic [127:0] key_in;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rk_out;

    modport master (
        output key_load,
        output key_in,
        output rd_idx,
        input  busy,
        input  keys_valid,
        input  rk_out
    );

    modport slave (
        input  key_load,
        input  key_in,
        input  rd_idx,
        output busy,
        output keys_valid,
        output rk_out
    );
endinterface

// File: rtl/key_expander.sv
// Sequential AES-128 key schedule: one round key per clock into an 11-entry
// bank, with a random-access read port for the cipher datapath.
module key_expander #(
    parameter int RD_REG = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    key_expander_if.slave kx
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EXPAND = 2'b01,
        ST_READY  = 2'b10
    } state_t;

    // AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX_TAB[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(r), 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Indices beyond rk10 read as zero.
    function automatic logic [127:0] select_key(input logic [10:0][127:0] bank, input logic [3:0] idx);
        return (idx <= 4'd10) ? bank[idx] : 128'h0;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [3:0]          cnt_r;
    logic [10:0][127:0]  rk_r;
    logic                load_s;
    logic [127:0]        prev_key_s;
    logic [127:0]        next_key_s;
    logic [127:0]        rd_data_s;
    logic                busy_s;
    logic                keys_valid_s;

    assign load_s     = kx.key_load && (state_r != ST_EXPAND);
    assign prev_key_s = select_key(rk_r, cnt_r - 4'd1);
    assign next_key_s = next_key(prev_key_s, cnt_r);
    assign rd_data_s  = select_key(rk_r, kx.rd_idx);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_s) state_next_s = ST_EXPAND;
                else        state_next_s = ST_IDLE;
            end
            ST_EXPAND: begin
                if (cnt_r == 4'd10) state_next_s = ST_READY;
                else                state_next_s = ST_EXPAND;
            end
            ST_READY: begin
                if (load_s) state_next_s = ST_EXPAND;
                else        state_next_s = ST_READY;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy_s       = 1'b0;
        keys_valid_s = 1'b0;
        case (state_r)
            ST_IDLE:   begin busy_s = 1'b0; keys_valid_s = 1'b0; end
            ST_EXPAND: begin busy_s = 1'b1; keys_valid_s = 1'b0; end
            ST_READY:  begin busy_s = 1'b0; keys_valid_s = 1'b1; end
            default:   begin busy_s = 1'b0; keys_valid_s = 1'b0; end
        endcase
    end

    assign kx.busy       = busy_s;
    assign kx.keys_valid = keys_valid_s;

    // Round counter: 1 on load, steps to 10 then parks at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else if (load_s) begin
            cnt_r <= 4'd1;
        end else if (state_r == ST_EXPAND) begin
            cnt_r <= (cnt_r == 4'd10) ? 4'd0 : cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Round-key bank: rk0 from the cipher key, then one derived key per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_r <= '0;
        end else if (load_s) begin
            rk_r[0] <= kx.key_in;
        end else if (state_r == ST_EXPAND) begin
            rk_r[cnt_r] <= next_key_s;
        end else begin
            rk_r <= rk_r;
        end
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [127:0] rk_out_r;
            // Registered read port; a same-cycle write is seen one cycle later.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rk_out_r <= 128'h0;
                end else begin
                    rk_out_r <= rd_data_s;
                end
            end
            assign kx.rk_out = rk_out_r;
        end else begin : g_rd_comb
            assign kx.rk_out = rd_data_s;
        end
    endgenerate

endmodule
